// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid register) with registered in_ready,
// flush/bubble insert and a saturating back-pressure cycle counter.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              in_ready_q;
  logic              accept, take;
  logic              load_main_in, load_main_skid, load_skid;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [RD_W-1:0]   main_rd,   skid_rd;
  logic              main_rw,   skid_rw;

  assign in_ready     = in_ready_q;
  assign out_valid    = (state != EMPTY);
  assign accept       = in_valid & in_ready_q;
  assign take         = out_valid & out_ready;
  assign out_data     = main_data;
  assign out_rd       = main_rd;
  assign out_regwrite = main_rw & out_valid;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    occupancy      = 2'd0;
    case (state)
      EMPTY: occupancy = 2'd0;
      ONE:   occupancy = 2'd1;
      FULL:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (take) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is derived from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_rd   <= '0;
      main_rw   <= 1'b0;
      skid_data <= '0;
      skid_rd   <= '0;
      skid_rw   <= 1'b0;
    end else if (flush) begin
      main_data <= '0;
      main_rd   <= '0;
      main_rw   <= 1'b0;
      skid_data <= '0;
      skid_rd   <= '0;
      skid_rw   <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_rd   <= in_rd;
        main_rw   <= in_regwrite;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_rd   <= skid_rd;
        main_rw   <= skid_rw;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_rd   <= in_rd;
        skid_rw   <= in_regwrite;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic          in_regwrite;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic          out_regwrite;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic          w;
  } ent_t;

  ent_t          q[$];
  ent_t          m_last;
  bit            m_ready;
  int            m_stall;

  pipe_stage_skid #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_ready(out_ready), .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_last  = '{d: '0, r: '0, w: 1'b0};
    m_ready = 1'b0;
    m_stall = 0;
  endtask

  // Drive one cycle of inputs, advance the reference model, sample 1 time unit after the edge
  task automatic cycle(input bit fl, input bit iv, input logic [DW-1:0] d,
                       input logic [RW-1:0] r, input bit w, input bit ordy);
    bit acc, tk;
    flush = fl; in_valid = iv; in_data = d; in_rd = r; in_regwrite = w; out_ready = ordy;
    acc = iv && m_ready;
    tk  = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy && (m_stall < (1 << CW) - 1)) m_stall++;
    if (fl) begin
      q.delete();
      m_last = '{d: '0, r: '0, w: 1'b0};
    end else begin
      if (tk)  void'(q.pop_front());
      if (acc) q.push_back('{d: d, r: r, w: w});
    end
    if (q.size() > 0) m_last = q[0];
    m_ready = (q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; in_valid = 0; in_data = '0; in_rd = '0; in_regwrite = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== '0 || out_rd !== '0 || out_regwrite !== 1'b0) begin
      errors++; $display("FAIL reset_payload got=%h/%h/%b exp=0/0/0", out_data, out_rd, out_regwrite); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    #3 rst_n = 1'b1;
    cycle(0, 0, '0, '0, 0, 1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vals [3];
    vals[0] = 16'h11; vals[1] = 16'h22; vals[2] = 16'h33;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, vals[i], 5'(i + 1), 1, 1);
      checks++; if (out_valid !== 1'b1 || out_data !== vals[i] || out_rd !== 5'(i + 1) || out_regwrite !== 1'b1) begin
        errors++; $display("FAIL stream_data[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_data, out_rd, vals[i], i + 1); end
      checks++; if (occupancy !== 2'd1 || stall_cnt !== '0) begin
        errors++; $display("FAIL stream_occ[%0d] got occ=%0d stall=%0d exp occ=1 stall=0", i, occupancy, stall_cnt); end
    end
    cycle(0, 0, '0, '0, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_data !== 16'h33) begin
      errors++; $display("FAIL stream_drain got=%b/%b/%h exp=0/0/0033", out_valid, out_regwrite, out_data); end
  endtask

  task automatic test_backpressure();
    cycle(0, 1, 16'hAA, 5'd3, 1, 0);
    checks++; if (occupancy !== 2'd1 || out_data !== 16'hAA || out_rd !== 5'd3) begin
      errors++; $display("FAIL bp_a got occ=%0d data=%h rd=%0d exp 1/00aa/3", occupancy, out_data, out_rd); end
    cycle(0, 1, 16'hBB, 5'd7, 0, 0);
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hAA) begin
      errors++; $display("FAIL bp_full got occ=%0d rdy=%b data=%h exp 2/0/00aa", occupancy, in_ready, out_data); end
    cycle(0, 1, 16'hEE, 5'd9, 1, 0);
    checks++; if (occupancy !== 2'd2 || out_data !== 16'hAA) begin
      errors++; $display("FAIL bp_hold got occ=%0d data=%h exp 2/00aa", occupancy, out_data); end
    cycle(0, 0, '0, '0, 0, 1);
    checks++; if (occupancy !== 2'd1 || out_data !== 16'hBB || out_rd !== 5'd7 || out_regwrite !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_b got occ=%0d data=%h rd=%0d rw=%b rdy=%b exp 1/00bb/7/0/1", occupancy, out_data, out_rd, out_regwrite, in_ready); end
    cycle(0, 0, '0, '0, 0, 1);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got occ=%0d vld=%b exp 0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    cycle(0, 1, 16'h0101, 5'd1, 1, 0);
    cycle(0, 1, 16'h0202, 5'd2, 1, 0);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup got occ=%0d exp 2", occupancy); end
    cycle(1, 1, 16'hCC, 5'd4, 1, 1);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || out_regwrite !== 1'b0 || out_rd !== '0) begin
      errors++; $display("FAIL flush_state got occ=%0d vld=%b data=%h rw=%b exp 0/0/0000/0", occupancy, out_valid, out_data, out_regwrite); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, '0, '0, 0, 1);
      checks++; if (out_valid !== 1'b0 || out_data === 16'hCC) begin
        errors++; $display("FAIL flush_dropped got vld=%b data=%h exp vld=0 data!=00cc", out_valid, out_data); end
    end
  endtask

  task automatic test_saturation();
    cycle(0, 1, 16'h5A5A, 5'd5, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, '0, 0, 0);
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_value got=%0d exp=15", stall_cnt); end
    cycle(0, 0, '0, '0, 0, 0);
    checks++; if (stall_cnt !== 4'd15 || out_data !== 16'h5A5A) begin
      errors++; $display("FAIL sat_hold got stall=%0d data=%h exp 15/5a5a", stall_cnt, out_data); end
    cycle(1, 0, '0, '0, 0, 1);
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush_keeps got=%0d exp=15", stall_cnt); end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 16'h1234, 5'd1, 1, 0);
    cycle(0, 1, 16'h5678, 5'd2, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== '0 || out_data !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset got vld=%b occ=%0d stall=%0d data=%h rdy=%b exp 0/0/0/0000/0", out_valid, occupancy, stall_cnt, out_data, in_ready); end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_pre_edge_ready got=%b exp=0", in_ready); end
    cycle(0, 0, '0, '0, 0, 1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1, DW'($urandom),
            RW'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      exp_d = m_last.d;
      checks++; if (out_valid !== (q.size() > 0) || occupancy !== 2'(q.size())) begin
        errors++; $display("FAIL rand_occ[%0d] got vld=%b occ=%0d exp vld=%b occ=%0d", i, out_valid, occupancy, q.size() > 0, q.size()); end
      checks++; if (out_data !== exp_d || out_rd !== m_last.r) begin
        errors++; $display("FAIL rand_payload[%0d] got=%h/%0d exp=%h/%0d", i, out_data, out_rd, exp_d, m_last.r); end
      checks++; if (out_regwrite !== ((q.size() > 0) ? m_last.w : 1'b0)) begin
        errors++; $display("FAIL rand_regwrite[%0d] got=%b", i, out_regwrite); end
      checks++; if (in_ready !== m_ready || stall_cnt !== CW'(m_stall)) begin
        errors++; $display("FAIL rand_ready_stall[%0d] got rdy=%b stall=%0d exp rdy=%b stall=%0d", i, in_ready, stall_cnt, m_ready, m_stall); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 64: payload width; a legal value is any integer of 1 or more.
REQ-002 Parameter RD_W, default 5: destination-register field width.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port flush  input  1  discard all held entries (bubble insert).
REQ-007 Port in_valid  input  1  upstream has an entry.
REQ-008 Port in_data  input  DATA_W  upstream payload (ALU result, read data and control bits, packed).
REQ-009 Port in_rd  input  RD_W  upstream destination register.
REQ-010 Port in_regwrite  input  1  upstream write-back enable.
REQ-011 Port in_ready  output  1  stage can accept; it is a registered signal.
REQ-012 Port out_valid  output  1  head entry valid.
REQ-013 Port out_data  output  DATA_W  head payload.
REQ-014 Port out_rd  output  RD_W  head destination register.
REQ-015 Port out_regwrite  output  1  head write-back enable, gated by out_valid.
REQ-016 Port out_ready  input  1  downstream takes the head entry.
REQ-017 Port occupancy  output  2  number of held entries (0..2).
REQ-018 Port stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-019 Define accept = in_valid & in_ready and take = out_valid & out_ready; there is no combinational path from out_ready to in_ready.
REQ-020 The block SHALL hold two entries: a main register driving the outputs and a skid register.
- State EMPTY: occupancy 0.
- State ONE: occupancy 1.
- State FULL: occupancy 2.
REQ-021 EMPTY: on accept, the input is loaded into main and the state goes to ONE; otherwise the state holds.
REQ-022 ONE: the SHALL transitions are:
- accept & take: main <= input; stay in ONE.
- accept & !take: skid <= input; go to FULL.
- !accept & take: go to EMPTY.
- neither: hold.
REQ-023 FULL: in_ready is 0; on take, main <= skid and the state goes to ONE; otherwise the state holds.
REQ-024 in_ready SHALL equal 1 in EMPTY and ONE and 0 in FULL, registered from the next state.
REQ-025 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-026 Latency is one cycle: an entry accepted at edge N appears at the outputs after edge N when the stage was EMPTY, or when it was ONE with take.
REQ-027 Entries SHALL leave in acceptance order; no entry is duplicated or lost unless flushed.
REQ-028 Held payload SHALL NOT change while out_valid=1 and out_ready=0.
REQ-029 Flush has priority over accept and take in the same cycle. After the edge:
- state is EMPTY;
- out_data, out_rd and out_regwrite are 0;
- in_ready is 1;
- any same-cycle input is dropped.
REQ-030 When out_valid=0, out_regwrite SHALL be 0; out_data and out_rd hold their last value, or 0 after a flush or reset.
REQ-031 stall_cnt SHALL increment by 1 on each edge with out_valid=1 and out_ready=0, and saturate at 2^CNT_W-1.
REQ-032 Flush SHALL NOT clear stall_cnt; only reset clears it.

Reset
REQ-033 While rst_n=0, the outputs SHALL take these values:
- state EMPTY, occupancy 0;
- out_valid 0, out_regwrite 0;
- out_data 0, out_rd 0;
- stall_cnt 0;
- in_ready 0.
REQ-034 in_ready SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-035 An assertion of rst_n mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-036 Streaming: out_ready=1; present 0x11, 0x22, 0x33 on consecutive cycles -> the three values appear one cycle later on consecutive cycles; occupancy stays 1; stall_cnt stays 0.
REQ-037 Back-pressure: set out_ready=0, then send A=0xAA with rd=3 and B=0xBB with rd=7.
- Response: occupancy reaches 2 and in_ready drops to 0.
- Then set out_ready=1 for 2 cycles -> A, then B, appear; occupancy returns to 0.
REQ-038 Flush while FULL: pulse flush together with in_valid=1 and data 0xCC.
- Next cycle: occupancy 0, out_valid 0, out_data 0, out_regwrite 0.
- 0xCC is never output.
REQ-039 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 and holds.
REQ-040 Asynchronous reset: assert rst_n=0 mid-cycle while FULL -> out_valid=0 and occupancy=0 before the next edge; in_ready=1 one edge after release.
